gold_ring_router: RTL and testbench
===================================

# gold_ring_router

Three-port bidirectional-ring router for the on-chip network: clockwise (cw) link, counter-clockwise (ccw) link and local processing-element (pe) port. Each node of the ring holds one instance between its two ring neighbours and its PE. Two virtual channels (VC0/VC1) are time-multiplexed by a global `polarity` signal. One-entry buffers sit at every input and output per VC, and round-robin arbitration resolves output contention.

## Interface
- PAC_WIDTH, 64, packet width. Field positions are fixed for 64 bits.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- polarity  in  1  global phase, toggles every cycle. Link VC = polarity; internal VC = ~polarity.
- cwsi / ccwsi / pesi  in  1  sender valid for the cw / ccw / pe input
- cwri / ccwri / peri  out  1  ready for the cw / ccw / pe input
- cwdi / ccwdi / pedi  in  PAC_WIDTH  input packet for the cw / ccw / pe input
- cwso / ccwso / peso  out  1  valid for the cw / ccw / pe output
- cwro / ccwro / pero  in  1  downstream ready for the cw / ccw / pe output
- cwdo / ccwdo / pedo  out  PAC_WIDTH  output packet for the cw / ccw / pe output

## Operation
- Packet fields:
  - [63] VC tag (informational; the buffer used is selected by polarity, not by this bit)
  - [62] dir: 0 = cw, 1 = ccw
  - [61:56] reserved, passed through unchanged
  - [55:48] hop, thermometer-coded, count = number of 1s
  - [47:0] payload
- Buffers: input buffers IB[port][vc] and output buffers OB[port][vc]. Each holds one packet plus a full flag.
- Input capture: `xri = ~IB[x][polarity].full`. On a clock edge with `xsi & xri`, `xdi` is written to IB[x][polarity].
- Routing, evaluated on the internal VC v = ~polarity:
  - cw input: hop[48]==0 → pe output. Otherwise hop >>= 1 and forward to the cw output.
  - ccw input: hop[48]==0 → pe output. Otherwise hop >>= 1 and forward to the ccw output.
  - pe input: dir selects the cw or ccw output, and hop >>= 1 (zero stays zero). A pe packet never ejects locally.
- Internal transfer: for each output and VC v, the requests come from full IB[*][v] entries routed to that output. If OB[out][v] is empty, one requester is granted. The modified packet moves to OB, the IB entry clears, and the OB entry sets.
- Arbitration, one round-robin pointer per output (shared by both VCs):
  - cw output: cw input vs pe input.
  - ccw output: ccw input vs pe input.
  - pe output: cw input vs ccw input.
  - Reset priority: ring input first for the cw/ccw outputs; cw input first for the pe output.
  - Pointer moves to the other requester after each grant. A loser stays in its IB and retries two cycles later.
- Output send:
  - `xso = OB[x][polarity].full` and `xdo = OB[x][polarity].data`.
  - On an edge with `xso & xro`, OB[x][polarity] clears.
  - xdo holds the last stored data when the buffer is empty.
- Link-VC buffers and internal-VC buffers are always disjoint, so no buffer is read and written in the same cycle.

## Timing
- Reset: all full flags 0, all data registers 0, pointers at reset priority. Therefore so=0, do=0, ri=1.
- Latency:
  - Capture at edge t (polarity=p).
  - Internal move at edge t+1.
  - Packet visible on xso/xdo during the cycle after t+1 (polarity=p again).
  - Leaves at edge t+2 if xro=1.
  - Zero-contention throughput: one packet per cycle per input, alternating VCs.
- Backpressure:
  - xro=0 holds the OB entry, which blocks the internal move for that VC.
  - A full IB then drops xri during that VC's link phase.
- A reset asserted mid-operation discards all buffered packets at the next edge.

## Structure
- Shared package: field constants (VC_BIT=63, DIR_BIT=62, HOP_HI=55, HOP_LO=48), port indices (CW, CCW, PE), and the packet width.
- Natural sub-module: `rr_arb2`, a two-requester round-robin arbiter with a pointer. The router instantiates three of them, one per output.
- Buffers live in the top level as register arrays with full flags.

## Test plan
- Reset 3 cycles, all ro=1 → every so=0, every do=0, every ri=1.
- cw stream, cwsi=1 each cycle with dir=0, hop=8'h01 → cwdo shows the same packet with hop=8'h00 one cycle after capture. peso stays 0.
- ccw stream, dir=1, hop=8'h03 → ccwdo carries hop=8'h01 with the payload intact.
- ccw stream with hop=8'h00 → packets appear on pedo unchanged. ccwso stays 0.
- pe stream with hop=8'h01 and dir alternating 0/1 → alternate packets appear on cwdo and ccwdo, each with hop=8'h00.
- Congestion: cw input and pe input, both dir=0 and hop=8'h01, valid in the same cycle → the cw packet leaves on cwdo first and the pe packet two cycles later. No loss; peri deasserts while blocked. With cwro=0, cwso holds and cwri falls once both VC buffers fill.

Source files
------------

// File: rtl/gold_ring_router_pkg.sv
// Shared definitions for the gold ring router: packet layout, port indices and
// the hop-count update applied to packets that keep travelling around the ring.
package gold_ring_router_pkg;

    localparam int unsigned PAC_WIDTH = 64;

    // Packet field positions (fixed for a 64-bit packet)
    localparam int unsigned VC_BIT  = 63;
    localparam int unsigned DIR_BIT = 62;
    localparam int unsigned HOP_HI  = 55;
    localparam int unsigned HOP_LO  = 48;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned NUM_VC    = 2;

    typedef logic [1:0] port_idx_t;

    localparam port_idx_t CW  = 2'd0;
    localparam port_idx_t CCW = 2'd1;
    localparam port_idx_t PE  = 2'd2;

    typedef logic [PAC_WIDTH-1:0] pkt_t;

    // One hop consumed: the thermometer-coded hop field loses its top 1.
    // A zero hop field stays zero.
    function automatic pkt_t hop_shift(input pkt_t pkt);
        pkt_t res;
        res                 = pkt;
        res[HOP_HI:HOP_LO]  = {1'b0, pkt[HOP_HI:HOP_LO+1]};
        return res;
    endfunction

endpackage

// File: rtl/gold_ring_router_rr_arb2.sv
// Two-requester round-robin arbiter. Requester 0 has priority out of reset;
// after every grant the pointer moves to the requester that was not granted.
// A grant is only issued when the destination can accept (en).
module gold_ring_router_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    // Grant selection: sole requester wins, the pointer breaks ties
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !ptr_q)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    // Pointer update: favour the other requester next time
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end else if (gnt[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gold_ring_router.sv
// Three-port bidirectional ring router node (cw link, ccw link, local PE).
// Two virtual channels are time-multiplexed by the global polarity signal: the
// link VC (= polarity) is captured from inputs and sent on outputs, while the
// internal VC (= ~polarity) is moved from input buffers to output buffers.
// Because the two VCs never coincide, no buffer is read and written in the
// same cycle.
module gold_ring_router
    import gold_ring_router_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 polarity,

    input  logic                 cwsi,
    output logic                 cwri,
    input  logic [PAC_WIDTH-1:0] cwdi,
    input  logic                 ccwsi,
    output logic                 ccwri,
    input  logic [PAC_WIDTH-1:0] ccwdi,
    input  logic                 pesi,
    output logic                 peri,
    input  logic [PAC_WIDTH-1:0] pedi,

    output logic                 cwso,
    input  logic                 cwro,
    output logic [PAC_WIDTH-1:0] cwdo,
    output logic                 ccwso,
    input  logic                 ccwro,
    output logic [PAC_WIDTH-1:0] ccwdo,
    output logic                 peso,
    input  logic                 pero,
    output logic [PAC_WIDTH-1:0] pedo
);

    // One-entry buffers per port and VC
    logic [NUM_PORTS-1:0][NUM_VC-1:0]                ib_full_q, ib_full_d;
    logic [NUM_PORTS-1:0][NUM_VC-1:0][PAC_WIDTH-1:0] ib_data_q, ib_data_d;
    logic [NUM_PORTS-1:0][NUM_VC-1:0]                ob_full_q, ob_full_d;
    logic [NUM_PORTS-1:0][NUM_VC-1:0][PAC_WIDTH-1:0] ob_data_q, ob_data_d;

    logic lnk;
    logic ivc;

    assign lnk = polarity;
    assign ivc = ~polarity;

    // Internal-VC view of the input buffers
    pkt_t cw_pkt, ccw_pkt, pe_pkt;

    assign cw_pkt  = ib_data_q[CW][ivc];
    assign ccw_pkt = ib_data_q[CCW][ivc];
    assign pe_pkt  = ib_data_q[PE][ivc];

    // Route decode: ring packets with hops left keep going, otherwise eject.
    // PE packets are steered by dir and never eject locally.
    logic cw_fwd, cw_ej, ccw_fwd, ccw_ej, pe_to_cw, pe_to_ccw;

    assign cw_fwd    = ib_full_q[CW][ivc]  &  cw_pkt[HOP_LO];
    assign cw_ej     = ib_full_q[CW][ivc]  & ~cw_pkt[HOP_LO];
    assign ccw_fwd   = ib_full_q[CCW][ivc] &  ccw_pkt[HOP_LO];
    assign ccw_ej    = ib_full_q[CCW][ivc] & ~ccw_pkt[HOP_LO];
    assign pe_to_cw  = ib_full_q[PE][ivc]  & ~pe_pkt[DIR_BIT];
    assign pe_to_ccw = ib_full_q[PE][ivc]  &  pe_pkt[DIR_BIT];

    // Per-output arbitration; requester 0 is the reset-priority input
    logic [1:0] gnt_cw, gnt_ccw, gnt_pe;

    gold_ring_router_rr_arb2 u_arb_cw (
        .clk   (clk),
        .reset (reset),
        .en    (~ob_full_q[CW][ivc]),
        .req   ({pe_to_cw, cw_fwd}),
        .gnt   (gnt_cw)
    );

    gold_ring_router_rr_arb2 u_arb_ccw (
        .clk   (clk),
        .reset (reset),
        .en    (~ob_full_q[CCW][ivc]),
        .req   ({pe_to_ccw, ccw_fwd}),
        .gnt   (gnt_ccw)
    );

    gold_ring_router_rr_arb2 u_arb_pe (
        .clk   (clk),
        .reset (reset),
        .en    (~ob_full_q[PE][ivc]),
        .req   ({ccw_ej, cw_ej}),
        .gnt   (gnt_pe)
    );

    // Packets moving into each output buffer and input buffers being drained
    pkt_t                 mv_cw, mv_ccw, mv_pe;
    logic [NUM_PORTS-1:0] ib_take;

    // Select the granted packet per output and flag the drained inputs
    always_comb begin
        mv_cw        = gnt_cw[0]  ? hop_shift(cw_pkt)  : hop_shift(pe_pkt);
        mv_ccw       = gnt_ccw[0] ? hop_shift(ccw_pkt) : hop_shift(pe_pkt);
        // Ejected packets already have an empty hop field
        mv_pe        = gnt_pe[0]  ? cw_pkt : ccw_pkt;
        ib_take      = '0;
        ib_take[CW]  = gnt_cw[0]  | gnt_pe[0];
        ib_take[CCW] = gnt_ccw[0] | gnt_pe[1];
        ib_take[PE]  = gnt_cw[1]  | gnt_ccw[1];
    end

    // Buffer next state: link-VC capture and send, internal-VC transfer
    always_comb begin
        ib_full_d = ib_full_q;
        ib_data_d = ib_data_q;
        ob_full_d = ob_full_q;
        ob_data_d = ob_data_q;

        // Capture into the link-VC input buffers
        if (cwsi && !ib_full_q[CW][lnk]) begin
            ib_full_d[CW][lnk] = 1'b1;
            ib_data_d[CW][lnk] = cwdi;
        end
        if (ccwsi && !ib_full_q[CCW][lnk]) begin
            ib_full_d[CCW][lnk] = 1'b1;
            ib_data_d[CCW][lnk] = ccwdi;
        end
        if (pesi && !ib_full_q[PE][lnk]) begin
            ib_full_d[PE][lnk] = 1'b1;
            ib_data_d[PE][lnk] = pedi;
        end

        // Internal-VC move from input to output buffers
        if (ib_take[CW]) begin
            ib_full_d[CW][ivc] = 1'b0;
        end
        if (ib_take[CCW]) begin
            ib_full_d[CCW][ivc] = 1'b0;
        end
        if (ib_take[PE]) begin
            ib_full_d[PE][ivc] = 1'b0;
        end
        if (|gnt_cw) begin
            ob_full_d[CW][ivc] = 1'b1;
            ob_data_d[CW][ivc] = mv_cw;
        end
        if (|gnt_ccw) begin
            ob_full_d[CCW][ivc] = 1'b1;
            ob_data_d[CCW][ivc] = mv_ccw;
        end
        if (|gnt_pe) begin
            ob_full_d[PE][ivc] = 1'b1;
            ob_data_d[PE][ivc] = mv_pe;
        end

        // Send from the link-VC output buffers; data is left in place
        if (ob_full_q[CW][lnk] && cwro) begin
            ob_full_d[CW][lnk] = 1'b0;
        end
        if (ob_full_q[CCW][lnk] && ccwro) begin
            ob_full_d[CCW][lnk] = 1'b0;
        end
        if (ob_full_q[PE][lnk] && pero) begin
            ob_full_d[PE][lnk] = 1'b0;
        end
    end

    // Buffer registers; reset discards every buffered packet
    always_ff @(posedge clk) begin
        if (reset) begin
            ib_full_q <= '0;
            ib_data_q <= '0;
            ob_full_q <= '0;
            ob_data_q <= '0;
        end else begin
            ib_full_q <= ib_full_d;
            ib_data_q <= ib_data_d;
            ob_full_q <= ob_full_d;
            ob_data_q <= ob_data_d;
        end
    end

    // Link-side handshake outputs
    assign cwri  = ~ib_full_q[CW][lnk];
    assign ccwri = ~ib_full_q[CCW][lnk];
    assign peri  = ~ib_full_q[PE][lnk];

    assign cwso  = ob_full_q[CW][lnk];
    assign ccwso = ob_full_q[CCW][lnk];
    assign peso  = ob_full_q[PE][lnk];

    assign cwdo  = ob_data_q[CW][lnk];
    assign ccwdo = ob_data_q[CCW][lnk];
    assign pedo  = ob_data_q[PE][lnk];

endmodule

// File: tb/tb_gold_ring_router.sv
// Bench for gold_ring_router: directed scenarios with hand-derived expectations
// plus a randomized run against a packet-level reference model.
module tb_gold_ring_router;

    localparam int W   = 64;
    localparam int CW  = 0;
    localparam int CCW = 1;
    localparam int PE  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         polarity;
    logic [2:0]   si, ri, so, ro;
    logic [W-1:0] di [3];
    logic [W-1:0] dq [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gold_ring_router dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .cwsi     (si[0]),
        .cwri     (ri[0]),
        .cwdi     (di[0]),
        .ccwsi    (si[1]),
        .ccwri    (ri[1]),
        .ccwdi    (di[1]),
        .pesi     (si[2]),
        .peri     (ri[2]),
        .pedi     (di[2]),
        .cwso     (so[0]),
        .cwro     (ro[0]),
        .cwdo     (dq[0]),
        .ccwso    (so[1]),
        .ccwro    (ro[1]),
        .ccwdo    (dq[1]),
        .peso     (so[2]),
        .pero     (ro[2]),
        .pedo     (dq[2])
    );

    // Reference model: buffers per port/VC, arbitration remembered as the
    // input that last won each output.
    logic [W-1:0] m_ib  [3][2];
    bit           m_ibf [3][2];
    logic [W-1:0] m_ob  [3][2];
    bit           m_obf [3][2];
    int           m_last [3];

    // Priority requester for each output, and the other contender
    function automatic int req_a(int o);
        return (o == PE) ? CW : o;
    endfunction

    function automatic int req_b(int o);
        return (o == PE) ? CCW : PE;
    endfunction

    function automatic int dest(int port, logic [W-1:0] pkt);
        if (port == PE) return pkt[62] ? CCW : CW;
        if ($countones(pkt[55:48]) == 0) return PE;
        return port;
    endfunction

    // Forwarded packets carry one hop fewer (thermometer of count-1)
    function automatic logic [W-1:0] xform(int port, logic [W-1:0] pkt);
        logic [W-1:0] r;
        int           n;
        r = pkt;
        n = $countones(pkt[55:48]);
        if (dest(port, pkt) != PE && n > 0) r[55:48] = 8'((1 << (n - 1)) - 1);
        return r;
    endfunction

    function automatic logic [W-1:0] mkr(logic dir, logic [7:0] hop);
        logic [W-1:0] r;
        r        = {$urandom(), $urandom()};
        r[62]    = dir;
        r[55:48] = hop;
        return r;
    endfunction

    function automatic logic [W-1:0] with_hop(logic [W-1:0] pkt, logic [7:0] hop);
        logic [W-1:0] r;
        r        = pkt;
        r[55:48] = hop;
        return r;
    endfunction

    task automatic m_clear();
        for (int x = 0; x < 3; x++) begin
            for (int v = 0; v < 2; v++) begin
                m_ib[x][v]  = '0;
                m_ibf[x][v] = 1'b0;
                m_ob[x][v]  = '0;
                m_obf[x][v] = 1'b0;
            end
            m_last[x] = req_b(x);
        end
    endtask

    // Advance the model by one edge using the inputs currently applied
    task automatic m_step();
        int p;
        int v;
        if (reset) begin
            m_clear();
            return;
        end
        p = int'(polarity);
        v = 1 - p;
        for (int x = 0; x < 3; x++) begin
            if (m_obf[x][p] && ro[x]) m_obf[x][p] = 1'b0;
            if (si[x] && !m_ibf[x][p]) begin
                m_ibf[x][p] = 1'b1;
                m_ib[x][p]  = di[x];
            end
        end
        for (int o = 0; o < 3; o++) begin
            int a;
            int b;
            int win;
            bit ra;
            bit rb;
            a   = req_a(o);
            b   = req_b(o);
            win = -1;
            ra  = m_ibf[a][v] && (dest(a, m_ib[a][v]) == o);
            rb  = m_ibf[b][v] && (dest(b, m_ib[b][v]) == o);
            if (!m_obf[o][v]) begin
                if (ra && rb) win = (m_last[o] == a) ? b : a;
                else if (ra) win = a;
                else if (rb) win = b;
            end
            if (win >= 0) begin
                m_obf[o][v]   = 1'b1;
                m_ob[o][v]    = xform(win, m_ib[win][v]);
                m_ibf[win][v] = 1'b0;
                m_last[o]     = win;
            end
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        polarity = ~polarity;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        si    = 3'b000;
        ro    = 3'b111;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            #1;
            for (int x = 0; x < 3; x++) begin
                vectors++;
                if (so[x] !== 1'b0 || dq[x] !== '0 || ri[x] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL reset port%0d ph%0d: so=%b do=%h ri=%b, required 0/0/1",
                             x, ph, so[x], dq[x], ri[x]);
                end
            end
            tick();
        end
    endtask

    task automatic test_cw_stream();
        logic [W-1:0] pk [8];
        do_reset();
        for (int i = 0; i < 8; i++) pk[i] = mkr(1'b0, 8'h01);
        for (int i = 0; i < 10; i++) begin
            si    = (i < 8) ? 3'b001 : 3'b000;
            di[0] = pk[(i < 8) ? i : 7];
            #1;
            if (i >= 2) begin
                vectors++;
                if (so[0] !== 1'b1 || dq[0] !== with_hop(pk[i-2], 8'h00) || so[2] !== 1'b0 ||
                    ri[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL cw_stream[%0d]: cwso=%b cwdo=%h peso=%b cwri=%b, required 1/%h/0/1",
                             i, so[0], dq[0], so[2], ri[0], with_hop(pk[i-2], 8'h00));
                end
            end
            tick();
        end
    endtask

    task automatic test_ccw_stream();
        logic [W-1:0] pk [6];
        do_reset();
        for (int i = 0; i < 6; i++) pk[i] = mkr(1'b1, 8'h03);
        for (int i = 0; i < 8; i++) begin
            si    = (i < 6) ? 3'b010 : 3'b000;
            di[1] = pk[(i < 6) ? i : 5];
            #1;
            if (i >= 2) begin
                vectors++;
                if (so[1] !== 1'b1 || dq[1] !== with_hop(pk[i-2], 8'h01)) begin
                    miscompares++;
                    $display("FAIL ccw_stream[%0d]: ccwso=%b ccwdo=%h, required 1/%h",
                             i, so[1], dq[1], with_hop(pk[i-2], 8'h01));
                end
            end
            tick();
        end
    endtask

    task automatic test_ccw_eject();
        logic [W-1:0] pk [6];
        do_reset();
        for (int i = 0; i < 6; i++) pk[i] = mkr(1'b1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            si    = (i < 6) ? 3'b010 : 3'b000;
            di[1] = pk[(i < 6) ? i : 5];
            #1;
            if (i >= 2) begin
                vectors++;
                if (so[2] !== 1'b1 || dq[2] !== pk[i-2] || so[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ccw_eject[%0d]: peso=%b pedo=%h ccwso=%b, required 1/%h/0",
                             i, so[2], dq[2], so[1], pk[i-2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_pe_stream();
        logic [W-1:0] pk [8];
        int           k;
        do_reset();
        for (int i = 0; i < 8; i++) pk[i] = mkr(i[0], 8'h01);
        for (int i = 0; i < 10; i++) begin
            si    = (i < 8) ? 3'b100 : 3'b000;
            di[2] = pk[(i < 8) ? i : 7];
            #1;
            if (i >= 2) begin
                k = i - 2;
                vectors++;
                if (k % 2 == 0) begin
                    if (so[0] !== 1'b1 || dq[0] !== with_hop(pk[k], 8'h00) || so[1] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL pe_stream[%0d]: cwso=%b cwdo=%h ccwso=%b, required 1/%h/0",
                                 i, so[0], dq[0], so[1], with_hop(pk[k], 8'h00));
                    end
                end else begin
                    if (so[1] !== 1'b1 || dq[1] !== with_hop(pk[k], 8'h00) || so[0] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL pe_stream[%0d]: ccwso=%b ccwdo=%h cwso=%b, required 1/%h/0",
                                 i, so[1], dq[1], so[0], with_hop(pk[k], 8'h00));
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_congestion();
        logic [W-1:0] a;
        logic [W-1:0] b;
        do_reset();
        a = mkr(1'b0, 8'h01);
        b = mkr(1'b0, 8'h01);
        for (int i = 0; i < 6; i++) begin
            si    = (i == 0) ? 3'b101 : 3'b000;
            di[0] = a;
            di[2] = b;
            #1;
            if (i == 2) begin
                vectors++;
                if (so[0] !== 1'b1 || dq[0] !== with_hop(a, 8'h00) || ri[2] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL congestion_first: cwso=%b cwdo=%h peri=%b, required 1/%h/0",
                             so[0], dq[0], ri[2], with_hop(a, 8'h00));
                end
            end
            if (i == 3 || i == 5) begin
                vectors++;
                if (so[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL congestion_gap[%0d]: cwso=%b, required 0", i, so[0]);
                end
            end
            if (i == 4) begin
                vectors++;
                if (so[0] !== 1'b1 || dq[0] !== with_hop(b, 8'h00) || ri[2] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL congestion_second: cwso=%b cwdo=%h peri=%b, required 1/%h/1",
                             so[0], dq[0], ri[2], with_hop(b, 8'h00));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] pk [8];
        do_reset();
        for (int i = 0; i < 8; i++) pk[i] = mkr(1'b0, 8'h01);
        for (int i = 0; i < 13; i++) begin
            si    = (i < 8) ? 3'b001 : 3'b000;
            ro    = (i < 8) ? 3'b110 : 3'b111;
            di[0] = pk[(i < 8) ? i : 7];
            #1;
            if (i < 4) begin
                vectors++;
                if (ri[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_ready[%0d]: cwri=%b, required 1", i, ri[0]);
                end
            end
            if (i >= 2 && i < 8) begin
                vectors++;
                if (so[0] !== 1'b1 || dq[0] !== with_hop(pk[i%2], 8'h00) ||
                    (i >= 4 && ri[0] !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL bp_hold[%0d]: cwso=%b cwdo=%h cwri=%b, required 1/%h/%0d",
                             i, so[0], dq[0], ri[0], with_hop(pk[i%2], 8'h00), (i < 4) ? 1 : 0);
                end
            end
            if (i >= 8 && i < 12) begin
                vectors++;
                if (so[0] !== 1'b1 || dq[0] !== with_hop(pk[i-8], 8'h00)) begin
                    miscompares++;
                    $display("FAIL bp_drain[%0d]: cwso=%b cwdo=%h, required 1/%h",
                             i, so[0], dq[0], with_hop(pk[i-8], 8'h00));
                end
            end
            if (i == 12) begin
                vectors++;
                if (so[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_empty: cwso=%b, required 0", so[0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        int p;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            reset = (i == 400) ? 1'b1 : 1'b0;
            for (int x = 0; x < 3; x++) begin
                si[x] = ($urandom_range(0, 2) != 0);
                ro[x] = ($urandom_range(0, 3) != 0);
                di[x] = mkr(1'($urandom_range(0, 1)),
                            8'((1 << $urandom_range(0, 3)) - 1));
            end
            #1;
            p = int'(polarity);
            for (int x = 0; x < 3; x++) begin
                vectors++;
                if (so[x] !== m_obf[x][p] || dq[x] !== m_ob[x][p] || ri[x] !== !m_ibf[x][p]) begin
                    miscompares++;
                    $display("FAIL random[%0d] port%0d: so=%b do=%h ri=%b, required %b/%h/%b",
                             i, x, so[x], dq[x], ri[x], m_obf[x][p], m_ob[x][p], !m_ibf[x][p]);
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        polarity = 1'b0;
        si       = 3'b000;
        ro       = 3'b111;
        for (int x = 0; x < 3; x++) di[x] = '0;
        m_clear();

        test_reset();
        test_cw_stream();
        test_ccw_stream();
        test_ccw_eject();
        test_pe_stream();
        test_congestion();
        test_backpressure();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
